// File: rtl/aes_pkg.sv
// Shared widths and FSM encoding for the AES word responder and its word packer.
package aes_pkg;
    localparam int WORD_W = 32;
    localparam int BLK_W  = 128;
    localparam int NWORDS = 4;
    localparam int SLOT_W = $clog2(NWORDS);

    typedef enum logic [1:0] {
        IDLE,
        START,
        BUSY,
        OUT
    } respState_e;
endpackage

// File: rtl/aes_word_pack.sv
// Word-to-block assembler: NWORDS slots written by index, slot 0 is the most significant word.
module aes_word_pack #(
    parameter int WORD_W = aes_pkg::WORD_W,
    parameter int NWORDS = aes_pkg::NWORDS,
    parameter int IDX_W  = aes_pkg::SLOT_W
) (
    input  logic                     Clk,
    input  logic                     rst,
    input  logic                     wrEn,
    input  logic [IDX_W-1:0]         wrIdx,
    input  logic [WORD_W-1:0]        wrWord,
    output logic [WORD_W*NWORDS-1:0] blk
);
    import aes_pkg::*;

    genvar gi;
    generate
        for (gi = 0; gi < NWORDS; gi++) begin : g_slot
            logic [WORD_W-1:0] slotReg;

            always_ff @(posedge Clk) begin
                if (!rst) begin
                    slotReg <= '0;
                end else if (wrEn && (wrIdx == IDX_W'(gi))) begin
                    slotReg <= wrWord;
                end
            end

            assign blk[WORD_W*(NWORDS-gi)-1 -: WORD_W] = slotReg;
        end
    endgenerate
endmodule

// File: rtl/aes_word_responder.sv
// Word-protocol responder: packs key/text words, starts the cipher core, streams the result MSW first.
// Optional sticky protocol error flag enabled by defining AES_RESP_PROTOCOL_ERR_EN.
module aes_word_responder #(
    parameter int WORD_W = aes_pkg::WORD_W,
    parameter int NWORDS = aes_pkg::NWORDS
) (
    input  logic                     Clk,
    input  logic                     rst,
    input  logic [WORD_W-1:0]        keyIn,
    input  logic [WORD_W-1:0]        wordIn,
    input  logic                     loadKey,
    input  logic                     readFlag,
    input  logic                     writeFlag,
    output logic                     done,
    output logic [WORD_W-1:0]        outBuf,
    output logic [WORD_W*NWORDS-1:0] core_key,
    output logic [WORD_W*NWORDS-1:0] core_state,
    output logic                     core_start,
    input  logic [WORD_W*NWORDS-1:0] core_result,
    input  logic                     core_done,
    output logic                     err
);
    import aes_pkg::*;

    localparam int            BW   = WORD_W * NWORDS;
    localparam int            CW   = $clog2(NWORDS);
    localparam logic [CW-1:0] LAST = CW'(NWORDS - 1);

    respState_e    stateReg, stateNext;
    logic [CW-1:0] kCntReg, kCntNext;
    logic [CW-1:0] tCntReg, tCntNext;
    logic [CW-1:0] oCntReg, oCntNext;
    logic          keyValidReg, keyValidNext;
    logic [BW-1:0] resultReg, resultNext;
    logic          keyWr, textWr;

    always_ff @(posedge Clk) begin
        if (!rst) begin
            stateReg    <= IDLE;
            kCntReg     <= '0;
            tCntReg     <= '0;
            oCntReg     <= '0;
            keyValidReg <= 1'b0;
            resultReg   <= '0;
        end else begin
            stateReg    <= stateNext;
            kCntReg     <= kCntNext;
            tCntReg     <= tCntNext;
            oCntReg     <= oCntNext;
            keyValidReg <= keyValidNext;
            resultReg   <= resultNext;
        end
    end

    always_comb begin
        stateNext    = stateReg;
        kCntNext     = kCntReg;
        tCntNext     = tCntReg;
        oCntNext     = oCntReg;
        keyValidNext = keyValidReg;
        resultNext   = resultReg;
        keyWr        = 1'b0;
        textWr       = 1'b0;
        case (stateReg)
            IDLE: begin
                keyWr  = readFlag & loadKey;
                textWr = readFlag & ~loadKey;
                if (keyWr) begin
                    kCntNext = (kCntReg == LAST) ? '0 : kCntReg + CW'(1);
                    if (kCntReg == LAST) keyValidNext = 1'b1;
                end
                // A text block completed without a key is dropped; the counter still wraps.
                if (textWr) begin
                    tCntNext = (tCntReg == LAST) ? '0 : tCntReg + CW'(1);
                    if ((tCntReg == LAST) && keyValidReg) stateNext = START;
                end
            end
            START: stateNext = BUSY;
            BUSY: begin
                if (core_done) begin
                    resultNext = core_result;
                    oCntNext   = '0;
                    stateNext  = OUT;
                end
            end
            OUT: begin
                if (writeFlag) begin
                    oCntNext = (oCntReg == LAST) ? '0 : oCntReg + CW'(1);
                    if (oCntReg == LAST) stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    aes_word_pack #(.WORD_W(WORD_W), .NWORDS(NWORDS), .IDX_W(CW)) uKeyPack (
        .Clk    (Clk),
        .rst    (rst),
        .wrEn   (keyWr),
        .wrIdx  (kCntReg),
        .wrWord (keyIn),
        .blk    (core_key)
    );

    aes_word_pack #(.WORD_W(WORD_W), .NWORDS(NWORDS), .IDX_W(CW)) uTextPack (
        .Clk    (Clk),
        .rst    (rst),
        .wrEn   (textWr),
        .wrIdx  (tCntReg),
        .wrWord (wordIn),
        .blk    (core_state)
    );

    logic [WORD_W-1:0] resWord [NWORDS];
    genvar gi;
    generate
        for (gi = 0; gi < NWORDS; gi++) begin : g_resWord
            assign resWord[gi] = resultReg[BW-1-gi*WORD_W -: WORD_W];
        end
    endgenerate

    assign core_start = (stateReg == START);
    assign done       = (stateReg == OUT);
    assign outBuf     = done ? resWord[oCntReg] : '0;

`ifdef AES_RESP_PROTOCOL_ERR_EN
    logic errReg;
    logic protoViolation;

    assign protoViolation = (readFlag && (stateReg != IDLE))
                          || (writeFlag && (stateReg != OUT))
                          || (textWr && (tCntReg == LAST) && !keyValidReg);

    always_ff @(posedge Clk) begin
        if (!rst) begin
            errReg <= 1'b0;
        end else if (protoViolation) begin
            errReg <= 1'b1;
        end
    end

    assign err = errReg;
`else
    assign err = 1'b0;
`endif
endmodule

// File: tb/tb_aes_word_responder.sv
// Scoreboard bench for aes_word_responder with a behavioural AES-128 core of fixed latency.
module tb_aes_word_responder;
    localparam int CORE_LAT = 10;

    logic         Clk;
    logic         rst;
    logic [31:0]  keyIn, wordIn;
    logic         loadKey, readFlag, writeFlag;
    logic         done;
    logic [31:0]  outBuf;
    logic [127:0] core_key, core_state, core_result;
    logic         core_start, core_done;
    logic         err;

    aes_word_responder #(.WORD_W(32), .NWORDS(4)) dut (
        .Clk         (Clk),
        .rst         (rst),
        .keyIn       (keyIn),
        .wordIn      (wordIn),
        .loadKey     (loadKey),
        .readFlag    (readFlag),
        .writeFlag   (writeFlag),
        .done        (done),
        .outBuf      (outBuf),
        .core_key    (core_key),
        .core_state  (core_state),
        .core_start  (core_start),
        .core_result (core_result),
        .core_done   (core_done),
        .err         (err)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;

    logic [255:0] startQ [$];
    logic [31:0]  outQ [$];

    // Reference model of the word protocol
    logic [31:0] mKey [4];
    logic [31:0] mText [4];
    int          kIdx, tIdx;
    bit          mKeyValid, mIdle, mErr, fipsOverride;

    logic [7:0] sbox [256];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic checkErr(input string name);
`ifdef AES_RESP_PROTOCOL_ERR_EN
        check(name, {127'd0, err}, {127'd0, mErr});
`else
        check(name, {127'd0, err}, 128'd0);
`endif
    endtask

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ a;
            a = xt(a);
        end
        return p;
    endfunction

    function automatic logic [127:0] aesEnc(input logic [127:0] key, input logic [127:0] pt);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [31:0]  w [44];
        logic [31:0]  tmp;
        logic [7:0]   rc, a0, a1, a2, a3;
        logic [127:0] r;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {sbox[tmp[31:24]], sbox[tmp[23:16]], sbox[tmp[15:8]], sbox[tmp[7:0]]} ^ {rc, 24'h0};
                rc  = xt(rc);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int i = 0; i < 16; i++) t[i] = sbox[s[(i%4) + 4*(((i/4) + (i%4)) % 4)]];
            if (rnd < 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                    t[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                    t[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                    t[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                    t[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
                end
            end
            for (int i = 0; i < 16; i++) s[i] = t[i] ^ w[4*rnd + i/4][31-8*(i%4) -: 8];
        end
        for (int i = 0; i < 16; i++) r[127-8*i -: 8] = s[i];
        return r;
    endfunction

    task automatic completeBlock();
        logic [127:0] k, t, r;
        k = {mKey[0], mKey[1], mKey[2], mKey[3]};
        t = {mText[0], mText[1], mText[2], mText[3]};
        startQ.push_back({k, t});
        r = fipsOverride ? 128'h69c4e0d86a7b0430d8cdb78070b4c55a : aesEnc(k, t);
        for (int i = 0; i < 4; i++) outQ.push_back(r[127-32*i -: 32]);
        mIdle = 1'b0;
    endtask

    task automatic doReset();
        rst = 1'b0; readFlag = 1'b0; writeFlag = 1'b0; loadKey = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        rst = 1'b1;
        startQ.delete(); outQ.delete();
        kIdx = 0; tIdx = 0; mKeyValid = 1'b0; mIdle = 1'b1; mErr = 1'b0;
        for (int i = 0; i < 4; i++) begin mKey[i] = '0; mText[i] = '0; end
    endtask

    // One word on readFlag for exactly one edge; calls chain back-to-back.
    task automatic sendWord(input bit isKey, input logic [31:0] w);
        readFlag = 1'b1;
        loadKey  = isKey;
        if (isKey) begin keyIn = w; wordIn = $urandom; end
        else       begin wordIn = w; keyIn = $urandom; end
        if (!mIdle) begin
            mErr = 1'b1;
        end else if (isKey) begin
            mKey[kIdx] = w;
            kIdx = (kIdx + 1) % 4;
            if (kIdx == 0) mKeyValid = 1'b1;
        end else begin
            mText[tIdx] = w;
            tIdx = (tIdx + 1) % 4;
            if (tIdx == 0) begin
                if (mKeyValid) completeBlock();
                else mErr = 1'b1;
            end
        end
        @(posedge Clk);
        #1;
        readFlag = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic pokeWrite();
        writeFlag = 1'b1;
        if (mIdle) mErr = 1'b1;
        @(posedge Clk);
        #1;
        writeFlag = 1'b0;
    endtask

    task automatic readOut(input bit withRead);
        int n;
        n = 0;
        while (!done && n < 200) begin
            @(posedge Clk);
            #1;
            n++;
        end
        check("done_rise", {127'd0, done}, 128'd1);
        if (!done) begin
            outQ.delete();
            return;
        end
        for (int i = 0; i < 4; i++) begin
            repeat ($urandom_range(0, 2)) begin @(posedge Clk); #1; end
            writeFlag = 1'b1;
            if (withRead && i == 1) begin
                readFlag = 1'b1; loadKey = 1'($urandom); keyIn = $urandom; wordIn = $urandom;
                mErr = 1'b1;
            end
            @(posedge Clk);
            #1;
            writeFlag = 1'b0;
            readFlag  = 1'b0;
        end
        check("done_fall", {127'd0, done}, 128'd0);
        mIdle = 1'b1;
    endtask

    // Output monitor: compares each consumed word against the scoreboard.
    initial begin
        logic [31:0] exp;
        forever begin
            @(negedge Clk);
            if (done && writeFlag) begin
                if (outQ.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL outBuf: got %h with no word expected", outBuf);
                end else begin
                    exp = outQ.pop_front();
                    check("outBuf", {96'd0, outBuf}, {96'd0, exp});
                    $display("out word %h expected %h", outBuf, exp);
                end
            end
        end
    end

    // Behavioural cipher core: checks the start request, answers after CORE_LAT cycles.
    initial begin
        logic [127:0] k, s;
        logic [255:0] e;
        core_done = 1'b0;
        core_result = '0;
        forever begin
            @(negedge Clk);
            if (core_start) begin
                k = core_key;
                s = core_state;
                $display("core start key %h text %h", k, s);
                if (startQ.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL core_start: got unexpected pulse key %h text %h", k, s);
                end else begin
                    e = startQ.pop_front();
                    check("core_key", k, e[255:128]);
                    check("core_state", s, e[127:0]);
                end
                @(negedge Clk);
                check("core_start_width", {127'd0, core_start}, 128'd0);
                repeat (CORE_LAT - 1) @(posedge Clk);
                #1;
                core_result = aesEnc(k, s);
                core_done = 1'b1;
                @(posedge Clk);
                #1;
                core_done = 1'b0;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] inv;
        logic [31:0] kw [4];
        logic [31:0] tw [4];
        bit reload;
        int ki, ti;

        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                          ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end

        keyIn = '0; wordIn = '0; fipsOverride = 1'b0;
        doReset();
        check("rst_done", {127'd0, done}, 128'd0);
        check("rst_outBuf", {96'd0, outBuf}, 128'd0);
        check("rst_core_start", {127'd0, core_start}, 128'd0);
        check("rst_core_key", core_key, 128'd0);
        check("rst_core_state", core_state, 128'd0);
        check("rst_err", {127'd0, err}, 128'd0);

        // Text with no key after reset is discarded
        for (int i = 0; i < 4; i++) sendWord(1'b0, $urandom);
        idle(15);
        check("nokey_done", {127'd0, done}, 128'd0);
        checkErr("nokey_err");
        doReset();

        // FIPS-197 vector
        fipsOverride = 1'b1;
        sendWord(1'b1, 32'h00010203); sendWord(1'b1, 32'h04050607);
        sendWord(1'b1, 32'h08090a0b); sendWord(1'b1, 32'h0c0d0e0f);
        sendWord(1'b0, 32'h00112233); sendWord(1'b0, 32'h44556677);
        sendWord(1'b0, 32'h8899aabb); sendWord(1'b0, 32'hccddeeff);
        fipsOverride = 1'b0;
        readOut(1'b0);
        checkErr("fips_err");

        // Key retention
        sendWord(1'b0, 32'hffeeddcc); sendWord(1'b0, 32'hbbaa9988);
        sendWord(1'b0, 32'h77665544); sendWord(1'b0, 32'h33221100);
        readOut(1'b0);

        // Protocol abuse: reads while busy, read alongside write, writes while idle
        for (int i = 0; i < 4; i++) sendWord(1'b0, $urandom);
        for (int i = 0; i < 3; i++) sendWord(1'($urandom), $urandom);
        readOut(1'b1);
        pokeWrite(); pokeWrite();
        check("abuse_done", {127'd0, done}, 128'd0);
        checkErr("abuse_err");
        for (int i = 0; i < 4; i++) sendWord(1'b0, $urandom);
        readOut(1'b0);

        // Interleaved key/text load
        doReset();
        sendWord(1'b1, $urandom); sendWord(1'b1, $urandom);
        sendWord(1'b0, $urandom); sendWord(1'b0, $urandom);
        sendWord(1'b1, $urandom); sendWord(1'b1, $urandom);
        sendWord(1'b0, $urandom); sendWord(1'b0, $urandom);
        readOut(1'b0);
        checkErr("interleave_err");

        // Reset while the core is busy
        for (int i = 0; i < 4; i++) sendWord(1'b0, $urandom);
        idle(3);
        doReset();
        idle(CORE_LAT + 5);
        check("midbusy_done", {127'd0, done}, 128'd0);
        check("midbusy_outBuf", {96'd0, outBuf}, 128'd0);
        check("midbusy_core_key", core_key, 128'd0);
        for (int i = 0; i < 4; i++) sendWord(1'b0, $urandom);
        idle(15);
        check("midbusy_nokey_done", {127'd0, done}, 128'd0);
        checkErr("midbusy_err");

        // Randomised interleaving with optional key reloads
        doReset();
        for (int it = 0; it < 10; it++) begin
            reload = (it == 0) || ($urandom_range(0, 1) == 1);
            for (int i = 0; i < 4; i++) begin kw[i] = $urandom; tw[i] = $urandom; end
            ki = reload ? 0 : 4;
            ti = 0;
            while (ki < 4 || ti < 4) begin
                if (ti >= 4 || (ki < 4 && $urandom_range(0, 1) == 1)) begin
                    sendWord(1'b1, kw[ki]); ki++;
                end else begin
                    sendWord(1'b0, tw[ti]); ti++;
                end
                if ($urandom_range(0, 3) == 0) idle(1);
            end
            if (!mIdle) readOut($urandom_range(0, 3) == 0);
        end
        idle(CORE_LAT + 5);
        checkErr("random_err");
        check("outQ_empty", 128'(outQ.size()), 128'd0);
        check("startQ_empty", 128'(startQ.size()), 128'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
